cpu_speed_ctrl: RTL and testbench

Upstream sequencer for the CPU clock mux. Debounces the user CPU speed switch and waits for the 68000 bus to be idle. It then drives `CPU_SPEED_SWITCH` with a single clean, registered transition and holds off further changes for a guard period, so the mux's cross-domain off/on handshake always completes. It runs on the always-present motherboard clock (the mux's `CLK1` source).

---
 rtl/cpu_speed_ctrl.sv | 110 +++++++++++
 tb/tb_cpu_speed_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cpu_speed_ctrl.sv
// cpu_speed_ctrl: sequencer in front of the CPU clock mux.
// Debounces the speed switch, waits for an idle 68000 bus, then issues a
// single clean toggle of CPU_SPEED_SWITCH followed by a guard window so the
// mux's cross-domain handoff can complete before any further change.
module cpu_speed_ctrl #(
    parameter int   DEBOUNCE_CYCLES = 71000,
    parameter int   GUARD_CYCLES    = 16,
    parameter logic RESET_SPEED     = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SW_IN,
    input  logic AS_n,
    output logic CPU_SPEED_SWITCH,
    output logic SWITCHING
);

    // One counter serves both the debounce and guard intervals, so it is
    // sized for the longer of the two (never narrower than one bit).
    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > GUARD_CYCLES) ? DEBOUNCE_CYCLES : GUARD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        WAIT_BUS = 2'd2,
        GUARD    = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic sw_meta;
    logic sw_s;
    logic as_meta;
    logic as_s;

    // Two-flop synchronizers for the mechanical switch and the address strobe;
    // the strobe resets to "bus idle" so nothing looks busy out of reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sw_meta <= RESET_SPEED;
            sw_s    <= RESET_SPEED;
            as_meta <= 1'b1;
            as_s    <= 1'b1;
        end else begin
            sw_meta <= SW_IN;
            sw_s    <= sw_meta;
            as_meta <= AS_n;
            as_s    <= as_meta;
        end
    end

    // Request sequencer: debounce, wait for bus idle, commit one toggle, guard.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state            <= IDLE;
            cnt              <= '0;
            CPU_SPEED_SWITCH <= RESET_SPEED;
            SWITCHING        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sw_s != CPU_SPEED_SWITCH) begin
                        state <= DEBOUNCE;
                        cnt   <= '0;
                    end
                end

                DEBOUNCE: begin
                    if (sw_s == CPU_SPEED_SWITCH) begin
                        state <= IDLE;
                    end else if (cnt == DEB_LAST) begin
                        state <= WAIT_BUS;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                WAIT_BUS: begin
                    if (sw_s == CPU_SPEED_SWITCH) begin
                        state <= IDLE;
                    end else if (as_s) begin
                        CPU_SPEED_SWITCH <= ~CPU_SPEED_SWITCH;
                        SWITCHING        <= 1'b1;
                        cnt              <= '0;
                        state            <= GUARD;
                    end
                end

                GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        SWITCHING <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_speed_ctrl.sv
// tb_cpu_speed_ctrl: directed bench for cpu_speed_ctrl with short debounce
// and guard intervals; expected values are hand-derived edge counts.
module tb_cpu_speed_ctrl;

    logic CLK;
    logic RESET;
    logic SW_IN;
    logic AS_n;
    logic CPU_SPEED_SWITCH;
    logic SWITCHING;

    int check_count;
    int pass_count;

    cpu_speed_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .GUARD_CYCLES   (4),
        .RESET_SPEED    (1'b0)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .SW_IN           (SW_IN),
        .AS_n            (AS_n),
        .CPU_SPEED_SWITCH(CPU_SPEED_SWITCH),
        .SWITCHING       (SWITCHING)
    );

    // Free-running 10-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance n rising edges, then settle 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic sw, input logic as_n);
        SW_IN = sw;
        AS_n  = as_n;
    endtask

    // Compare both outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic exp_speed, input logic exp_sw);
        check_count++;
        assert (CPU_SPEED_SWITCH === exp_speed) pass_count++;
        else $error("[TB] FAIL %s speed: observed %b expected %b", tag, CPU_SPEED_SWITCH, exp_speed);
        check_count++;
        assert (SWITCHING === exp_sw) pass_count++;
        else $error("[TB] FAIL %s switching: observed %b expected %b", tag, SWITCHING, exp_sw);
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        RESET = 1'b0;
        applyStimulus(1'b1, 1'b1);

        // 1: asynchronous reset with the switch already high, no edge needed
        #2 RESET = 1'b1;
        #1 checkOutput("reset_async", 1'b0, 1'b0);
        tick(2);
        checkOutput("reset_held", 1'b0, 1'b0);

        // 2: clean 0->1 switch, bus idle; toggle at edge 12, guard edges 12-15
        RESET = 1'b0;
        tick(11);
        checkOutput("clean_e11", 1'b0, 1'b0);
        tick(1);
        checkOutput("clean_e12", 1'b1, 1'b1);
        for (int e = 13; e <= 15; e++) begin
            tick(1);
            checkOutput($sformatf("clean_e%0d", e), 1'b1, 1'b1);
        end
        tick(1);
        checkOutput("clean_e16", 1'b1, 1'b0);
        tick(3);
        checkOutput("clean_settled", 1'b1, 1'b0);

        // 6: reset pulse at edge 13 of a fresh commit, then full re-run
        RESET = 1'b1;
        #1 checkOutput("r6_reset", 1'b0, 1'b0);
        tick(1);
        RESET = 1'b0;
        tick(12);
        checkOutput("r6_e12", 1'b1, 1'b1);
        tick(1);
        RESET = 1'b1;
        #1 checkOutput("r6_midguard_async", 1'b0, 1'b0);
        tick(1);
        checkOutput("r6_midguard_held", 1'b0, 1'b0);
        RESET = 1'b0;
        tick(11);
        checkOutput("r6_rel_e11", 1'b0, 1'b0);
        tick(1);
        checkOutput("r6_rel_e12", 1'b1, 1'b1);
        tick(4);
        checkOutput("r6_rel_e16", 1'b1, 1'b0);

        // 3: bounce, switch high 5 cycles then low 5 cycles, three times
        RESET = 1'b1;
        applyStimulus(1'b0, 1'b1);
        tick(1);
        RESET = 1'b0;
        tick(4);
        checkOutput("bounce_start", 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b1, 1'b1);
            for (int c = 0; c < 5; c++) begin
                tick(1);
                checkOutput($sformatf("bounce_hi_r%0d_c%0d", r, c), 1'b0, 1'b0);
            end
            applyStimulus(1'b0, 1'b1);
            for (int c = 0; c < 5; c++) begin
                tick(1);
                checkOutput($sformatf("bounce_lo_r%0d_c%0d", r, c), 1'b0, 1'b0);
            end
        end
        tick(12);
        checkOutput("bounce_after", 1'b0, 1'b0);

        // 4: bus busy; WAIT_BUS at edge 11, strobe low 20 more cycles
        applyStimulus(1'b1, 1'b0);
        tick(11);
        checkOutput("busy_e11", 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            tick(1);
            checkOutput($sformatf("busy_hold_%0d", c), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1);
        tick(2);
        checkOutput("busy_rise_e2", 1'b0, 1'b0);
        tick(1);
        checkOutput("busy_rise_e3", 1'b1, 1'b1);
        tick(3);
        checkOutput("busy_guard_last", 1'b1, 1'b1);
        tick(1);
        checkOutput("busy_guard_done", 1'b1, 1'b0);

        // 5: abort in WAIT_BUS by returning the switch, then release strobe
        applyStimulus(1'b0, 1'b0);
        tick(11);
        checkOutput("abort_wait_e11", 1'b1, 1'b0);
        tick(5);
        checkOutput("abort_wait_e16", 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        tick(5);
        checkOutput("abort_idle", 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick(1);
            checkOutput($sformatf("abort_as_rise_%0d", c), 1'b1, 1'b0);
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
